// File: rtl/cache_arbiter_pkg.sv
// cache_arbiter_pkg: shared arbiter state/op types and default line/address widths (package arbiter_types)
package arbiter_types;
  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, GAP} arb_state_t;
  typedef enum logic {OP_READ, OP_WRITE} arb_op_t;
endpackage

// File: rtl/cache_arbiter_ctrl.sv
// cache_arbiter_ctrl: arbitration FSM issuing one-cycle latch strobes for the granted side.
// Optional CACHE_ARB_RR_EN swaps fixed D priority for alternating grant on contention.
module cache_arbiter_ctrl
  import arbiter_types::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_read,
  input  logic       d_read,
  input  logic       d_write,
  input  logic       pmem_resp,
  output arb_state_t state,
  output logic       latch_i,
  output logic       latch_d
);
  arb_state_t next;
  logic want_d, grant_d;
  assign want_d = d_read | d_write;
`ifdef CACHE_ARB_RR_EN
  logic last_grant;
  // last_grant 1 means D won the previous arbitration
  assign grant_d = want_d & (~i_read | ~last_grant);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) last_grant <= 1'b0;
    else if (latch_i | latch_d) last_grant <= latch_d;
`else
  assign grant_d = want_d;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next    = state;
    latch_i = 1'b0;
    latch_d = 1'b0;
    case (state)
      IDLE: begin
        latch_d = grant_d;
        latch_i = i_read & ~grant_d;
        next    = grant_d ? SERVE_D : i_read ? SERVE_I : IDLE;
      end
      SERVE_I, SERVE_D: next = pmem_resp ? GAP : state;
      default: next = IDLE;
    endcase
  end
endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter: serialises icache/dcache line misses onto one memory port.
// Define CACHE_ARB_RR_EN for round-robin grant instead of fixed D-over-I priority.
module cache_arbiter #(
  parameter int LINE_W = arbiter_types::LINE_W,
  parameter int ADDR_W = arbiter_types::ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);
  import arbiter_types::*;
  arb_state_t        state;
  logic              latch_i, latch_d, serving;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  arb_op_t           op_q;
  cache_arbiter_ctrl u_ctrl (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_read   (i_read),
    .d_read   (d_read),
    .d_write  (d_write),
    .pmem_resp(pmem_resp),
    .state    (state),
    .latch_i  (latch_i),
    .latch_d  (latch_d)
  );
  // write beats read when the dcache raises both
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= OP_READ;
    end else if (latch_d) begin
      addr_q  <= d_address;
      wdata_q <= d_wdata;
      op_q    <= arb_op_t'(d_write);
    end else if (latch_i) begin
      addr_q  <= i_address;
      op_q    <= OP_READ;
    end
  assign serving      = (state == SERVE_I) || (state == SERVE_D);
  assign pmem_read    = serving && (op_q == OP_READ);
  assign pmem_write   = serving && (op_q == OP_WRITE);
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign i_resp       = (state == SERVE_I) && pmem_resp;
  assign d_resp       = (state == SERVE_D) && pmem_resp;
  assign i_rdata      = i_resp ? pmem_rdata : '0;
  assign d_rdata      = d_resp ? pmem_rdata : '0;
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed plus random stimulus checked against a transaction-level arbiter model.
module tb_cache_arbiter;
  import arbiter_types::*;
  localparam int LW = LINE_W;
  localparam int AW = ADDR_W;
  logic          clk = 1'b0, reset_n = 1'b0;
  logic          i_read = 1'b0, d_read = 1'b0, d_write = 1'b0, pmem_resp = 1'b0;
  logic [AW-1:0] i_address = '0, d_address = '0;
  logic [LW-1:0] d_wdata = '0, pmem_rdata = '0;
  logic [LW-1:0] i_rdata, d_rdata, pmem_wdata;
  logic [AW-1:0] pmem_address;
  logic          i_resp, d_resp, pmem_read, pmem_write;
  int checks = 0, failures = 0;
  // model: an in-flight transaction, a post-completion gap countdown, and who won last
  bit            busy = 0, cur_d = 0, cur_wr = 0, last_d = 0;
  int            cool = 0;
  logic [AW-1:0] cur_addr = '0;
  logic [LW-1:0] cur_wdata = '0;
  cache_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );
  always #5 clk = ~clk;
  task automatic check(string tag, logic [LW-1:0] got, logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction
  task automatic step(bit ir, logic [AW-1:0] ia, bit dr, bit dw, logic [AW-1:0] da,
                      logic [LW-1:0] dwd, bit rsp, logic [LW-1:0] rd);
    bit done, take_d;
    @(negedge clk);
    i_read = ir; i_address = ia; d_read = dr; d_write = dw; d_address = da;
    d_wdata = dwd; pmem_resp = rsp; pmem_rdata = rd;
    #1;
    done = busy && rsp;
    check("pmem_read", pmem_read, busy && !cur_wr);
    check("pmem_write", pmem_write, busy && cur_wr);
    if (busy) check("pmem_address", pmem_address, cur_addr);
    if (busy && cur_wr) check("pmem_wdata", pmem_wdata, cur_wdata);
    check("i_resp", i_resp, done && !cur_d);
    check("d_resp", d_resp, done && cur_d);
    check("i_rdata", i_rdata, (done && !cur_d) ? rd : '0);
    check("d_rdata", d_rdata, (done && cur_d) ? rd : '0);
    if (busy) begin
      if (rsp) begin busy = 0; cool = 1; end
    end else if (cool > 0) cool--;
    else if (ir || dr || dw) begin
`ifdef CACHE_ARB_RR_EN
      take_d = (dr || dw) && (!ir || !last_d);
`else
      take_d = dr || dw;
`endif
      busy = 1;
      cur_d = take_d;
      cur_wr = take_d && dw;
      cur_addr = take_d ? da : ia;
      if (take_d) cur_wdata = dwd;
      last_d = take_d;
    end
  endtask
  task automatic idle_steps(int n, bit rsp);
    for (int k = 0; k < n; k++) step(0, '0, 0, 0, '0, '0, rsp, rnd_line());
  endtask
  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0; i_read = 1'b1; pmem_resp = 1'b1; pmem_rdata = rnd_line();
    #1;
    check("rst_pmem_read", pmem_read, 0);
    check("rst_pmem_write", pmem_write, 0);
    check("rst_i_resp", i_resp, 0);
    check("rst_d_resp", d_resp, 0);
    check("rst_i_rdata", i_rdata, '0);
    check("rst_d_rdata", d_rdata, '0);
    check("rst_address", pmem_address, '0);
    check("rst_wdata", pmem_wdata, '0);
    repeat (2) @(negedge clk);
    check("rst_hold_read", pmem_read, 0);
    check("rst_hold_i_resp", i_resp, 0);
    i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0; reset_n = 1'b1;
    busy = 0; cool = 0; last_d = 0;
  endtask
  initial begin
    logic [LW-1:0] beef, w1;
    beef = {8{32'hDEADBEEF}};
    w1 = {8{32'h12345678}};
    apply_reset();
    // I-only fill, memory answers after 5 strobe cycles
    step(1, 32'h60, 0, 0, '0, '0, 0, '0);
    for (int k = 0; k < 4; k++) step(1, 32'h60, 0, 0, '0, '0, 0, '0);
    step(1, 32'h60, 0, 0, '0, '0, 1, beef);
    idle_steps(4, 0);
    // simultaneous I and D reads, both held
    for (int k = 0; k < 4; k++) step(1, 32'h200, 1, 0, 32'h1000, '0, 0, '0);
    step(1, 32'h200, 1, 0, 32'h1000, '0, 1, rnd_line());
    for (int k = 0; k < 3; k++) step(1, 32'h200, 0, 0, '0, '0, 0, '0);
    step(1, 32'h200, 0, 0, '0, '0, 1, rnd_line());
    idle_steps(3, 0);
    // writeback with wdata changing afterwards, then a fill
    step(0, '0, 0, 1, 32'h2000, w1, 0, '0);
    for (int k = 0; k < 3; k++) step(0, '0, 1, 0, 32'h3000, '0, 0, '0);
    step(0, '0, 1, 0, 32'h3000, '0, 1, '0);
    for (int k = 0; k < 4; k++) step(0, '0, 1, 0, 32'h3000, '0, 0, '0);
    step(0, '0, 0, 0, '0, '0, 1, rnd_line());
    idle_steps(3, 0);
    // read and write raised together
    step(0, '0, 1, 1, 32'h4000, w1, 0, '0);
    idle_steps(2, 0);
    idle_steps(1, 1);
    idle_steps(4, 1);
    // reset three cycles into an I fill, then a stray response
    step(1, 32'h5000, 0, 0, '0, '0, 0, '0);
    for (int k = 0; k < 3; k++) step(1, 32'h5000, 0, 0, '0, '0, 0, '0);
    apply_reset();
    idle_steps(3, 1);
    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 1), {$urandom} & ~32'h1F,
           $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 3, {$urandom} & ~32'h1F,
           rnd_line(), $urandom_range(0, 9) < 3, rnd_line());
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
Arbitrates L1 instruction-cache and L1 data-cache line misses onto a single physical-memory (or L2) port. It sits directly downstream of the icache/dcache pair that serve the pipelined core's read_a/read_b ports. The block serialises one 256-bit line transaction at a time and routes the response back to the granted requester. The D-side has fixed priority by default, since a MEM-stage stall freezes the whole pipe.

Parameters:
- LINE_W, 256: cache line width in bits.
- ADDR_W, 32: byte address width; line-aligned addresses are passed through unmodified.

Ports:
- clk, in, 1: clock, rising edge.
- reset_n, in, 1: asynchronous active-low reset.
- i_read, in, 1: icache line-fill request.
- i_address, in, ADDR_W: icache miss address.
- i_rdata, out, LINE_W: fill data to icache.
- i_resp, out, 1: one-cycle completion pulse to icache.
- d_read, in, 1: dcache line-fill request.
- d_write, in, 1: dcache writeback request.
- d_address, in, ADDR_W: dcache request address.
- d_wdata, in, LINE_W: dcache writeback line.
- d_rdata, out, LINE_W: fill data to dcache.
- d_resp, out, 1: one-cycle completion pulse to dcache.
- pmem_read, out, 1: memory read strobe.
- pmem_write, out, 1: memory write strobe.
- pmem_address, out, ADDR_W: memory address.
- pmem_wdata, out, LINE_W: memory write line.
- pmem_rdata, in, LINE_W: memory read line.
- pmem_resp, in, 1: memory completion.

Behaviour:
- Reset value of every output:
  - reset_n low forces state IDLE and clears the latched address, wdata and op.
  - All strobes and resp outputs go to 0 immediately (asynchronous); rdata outputs are 0.
- States: IDLE, SERVE_I, SERVE_D, GAP.
- IDLE:
  - If d_read or d_write is high, latch d_address, d_wdata and op, then go to SERVE_D.
  - Else if i_read is high, latch i_address, then go to SERVE_I.
  - pmem strobes are 0.
- SERVE_x:
  - pmem_read/pmem_write/pmem_address/pmem_wdata are driven from the latched registers only, never from live inputs.
  - Strobes are held until pmem_resp.
  - Earliest strobe is one cycle after the request is sampled.
- Completion:
  - On the pmem_resp cycle, the granted side's resp = 1 and its rdata = pmem_rdata (combinational pass-through, same cycle).
  - The non-granted resp stays 0 and its rdata output reads 0.
  - Next state is GAP.
- GAP:
  - One idle cycle so the requester can drop its request; no new grant is made.
  - Then go to IDLE.
  - Back-to-back transactions are therefore separated by exactly 2 cycles after pmem_resp.
- Illegal case, d_read and d_write both high: the write wins and a single write transaction is issued.
- pmem_resp arriving in IDLE or GAP is ignored; no resp is generated.
- A request dropped mid-transaction is ignored; the latched transaction completes and the resp pulse is still issued.
- reset_n asserted mid-transaction aborts immediately. Any pmem_resp after reset release is ignored because state is IDLE.
- Requests held high across GAP are re-arbitrated in IDLE. Under fixed priority, continuous D traffic can starve the I side (this is the documented default).

Optional Feature:
- Macro: CACHE_ARB_RR_EN.
- When defined:
  - A 1-bit last_grant register (reset 0 = I) is updated on every grant.
  - If both sides request in IDLE, the side not granted last wins; a single requester always wins.
  - A d_read/d_write conflict still resolves to write.
- When undefined: fixed D-over-I priority, and no last_grant register exists.

Decomposition:
- Shared package arbiter_types holds:
  - arb_state_t enum (IDLE, SERVE_I, SERVE_D, GAP).
  - arb_op_t (OP_READ, OP_WRITE).
  - LINE_W and ADDR_W default constants, shared with the cache modules.
- One natural sub-module, cache_arbiter_ctrl: the FSM plus grant logic (and last_grant under CACHE_ARB_RR_EN), emitting grant/latch/state.
- The top holds the address/wdata latches and the response mux.

Test Plan:
1. Reset check: hold reset_n = 0 while i_read = 1 and pmem_resp = 1. Expect all outputs 0 and no strobes. Release, sample i_read; pmem_read rises exactly 1 cycle later with pmem_address = i_address.
2. I-only fill: i_read = 1, i_address = 0x0000_0060; memory responds after 5 cycles with rdata = {8{32'hDEADBEEF}}. Expect i_resp pulse of 1 cycle with matching i_rdata, d_resp = 0, and a GAP cycle before any new strobe.
3. Simultaneous requests: i_read and d_read both asserted in the same cycle, d_address = 0x0000_1000. D is serviced first. I starts exactly 2 cycles after D's pmem_resp. Under CACHE_ARB_RR_EN, start from last_grant = D and expect I first.
4. Writeback then fill: d_write = 1 with d_wdata = {8{32'h12345678}}; change d_wdata to 0 the following cycle. pmem_wdata stays at the latched value until pmem_resp; then d_read is served.
5. Illegal d_read = d_write = 1: exactly one transaction with pmem_write = 1 and pmem_read = 0.
6. Mid-transaction reset: assert reset_n low 3 cycles into SERVE_I. Strobes drop immediately. A pmem_resp after release produces no i_resp/d_resp pulse.
